// File: rtl/cntr593_pkg.sv
// Shared types and idle pin values for the 74593 strobe sequencer.
// pins_for() maps FSM state and current op onto the chip strobe levels.
package cntr593_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Encoding matches the done_op output
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_CLR  = 2'b01,
    OP_LOAD = 2'b10,
    OP_INC  = 2'b11
  } op_e;

  typedef struct packed {
    logic rck;
    logic rcken_bar;
    logic cload_bar;
    logic cck;
    logic ccken;
    logic ccken_bar;
    logic cclr_bar;
  } pins_t;

  localparam pins_t PINS_IDLE = '{rck: 1'b0, rcken_bar: 1'b1, cload_bar: 1'b1,
                                  cck: 1'b1, ccken: 1'b0, ccken_bar: 1'b1,
                                  cclr_bar: 1'b1};

  function automatic pins_t pins_for(input state_e st, input op_e op);
    pins_t p;
    p = PINS_IDLE;
    unique case (op)
      OP_CLR: begin
        // Clear is held across the CCK rise at the start of PH2
        if (st == PH1) begin p.cclr_bar = 1'b0; p.cck = 1'b0; end
        if (st == PH2) begin p.cclr_bar = 1'b0; end
      end
      OP_LOAD: begin
        if (st == PH1) begin p.rcken_bar = 1'b0; end
        if (st == PH2) begin p.rcken_bar = 1'b0; p.rck = 1'b1; end
        if (st == PH3) begin p.cload_bar = 1'b0; end
      end
      OP_INC: begin
        if (st == PH1) begin p.ccken = 1'b1; p.ccken_bar = 1'b0; p.cck = 1'b0; end
        if (st == PH2) begin p.ccken = 1'b1; p.ccken_bar = 1'b0; end
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cntr593_seq.sv
// Sequencer turning clr/load/inc requests into settle-timed 74593 strobe
// edges; all outputs registered, shadow register predicts the counter.
module cntr593_seq
  import cntr593_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             clr_req,
  input  logic             load_req,
  input  logic             inc_req,
  input  logic [WIDTH-1:0] load_data,
  input  logic             oe_req,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_op,
  output logic [WIDTH-1:0] inQ,
  output logic             RCK,
  output logic             RCKEN_bar,
  output logic             CLOAD_bar,
  output logic             CCK,
  output logic             CCKEN,
  output logic             CCKEN_bar,
  output logic             CCLR_bar,
  output logic             G,
  output logic             G_bar,
  output logic [WIDTH-1:0] shadow,
  output logic             shadow_valid,
  output logic             shadow_rco_bar
);

  localparam int PW = $clog2(SETTLE + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SETTLE - 1);

  state_e           state_reg, state_next;
  op_e              op_reg, op_next;
  logic [PW-1:0]    ph_cnt_reg, ph_cnt_next;
  logic             phase_end;
  pins_t            pins_reg;
  logic             busy_reg, done_reg;
  op_e              done_op_reg;
  logic [WIDTH-1:0] inq_reg, inq_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             valid_reg, valid_next;
  logic             rco_bar_reg;
  logic             g_reg, g_bar_reg;

  assign phase_end = (ph_cnt_reg == PH_LAST);

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    ph_cnt_next = ph_cnt_reg;
    inq_next    = inq_reg;
    unique case (state_reg)
      IDLE: begin
        ph_cnt_next = '0;
        if (clr_req) begin
          op_next    = OP_CLR;
          state_next = PH1;
        end else if (load_req) begin
          op_next    = OP_LOAD;
          state_next = PH1;
          inq_next   = load_data;
        end else if (inc_req) begin
          op_next    = OP_INC;
          state_next = PH1;
        end
      end
      PH1, PH2, PH3, PH4: begin
        ph_cnt_next = phase_end ? '0 : ph_cnt_reg + PW'(1);
        if (phase_end) begin
          unique case (state_reg)
            PH1:     state_next = PH2;
            PH2:     state_next = (op_reg == OP_INC) ? DONE : PH3;
            PH3:     state_next = (op_reg == OP_LOAD) ? PH4 : DONE;
            default: state_next = DONE;
          endcase
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The chip latches on the PH2 edge, so the shadow follows on leaving PH2
  always_comb begin
    shadow_next = shadow_reg;
    valid_next  = valid_reg;
    if (state_reg == PH2 && phase_end) begin
      unique case (op_reg)
        OP_CLR:  begin shadow_next = '0;      valid_next = 1'b1; end
        OP_LOAD: begin shadow_next = inq_reg; valid_next = 1'b1; end
        OP_INC:  shadow_next = shadow_reg + WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_reg   <= IDLE;
      op_reg      <= OP_NONE;
      ph_cnt_reg  <= '0;
      pins_reg    <= PINS_IDLE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      done_op_reg <= OP_NONE;
      inq_reg     <= '0;
      shadow_reg  <= '0;
      valid_reg   <= 1'b0;
      rco_bar_reg <= 1'b1;
      g_reg       <= 1'b0;
      g_bar_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      ph_cnt_reg  <= ph_cnt_next;
      pins_reg    <= pins_for(state_next, op_next);
      busy_reg    <= (state_next != IDLE) && (state_next != DONE);
      done_reg    <= (state_next == DONE);
      done_op_reg <= (state_next == DONE) ? op_next : OP_NONE;
      inq_reg     <= inq_next;
      shadow_reg  <= shadow_next;
      valid_reg   <= valid_next;
      rco_bar_reg <= ~&shadow_next;
      g_reg       <= oe_req;
      g_bar_reg   <= ~oe_req;
    end
  end

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign done_op        = done_op_reg;
  assign inQ            = inq_reg;
  assign RCK            = pins_reg.rck;
  assign RCKEN_bar      = pins_reg.rcken_bar;
  assign CLOAD_bar      = pins_reg.cload_bar;
  assign CCK            = pins_reg.cck;
  assign CCKEN          = pins_reg.ccken;
  assign CCKEN_bar      = pins_reg.ccken_bar;
  assign CCLR_bar       = pins_reg.cclr_bar;
  assign G              = g_reg;
  assign G_bar          = g_bar_reg;
  assign shadow         = shadow_reg;
  assign shadow_valid   = valid_reg;
  assign shadow_rco_bar = rco_bar_reg;

endmodule

// File: tb/tb_cntr593_seq.sv
// Scoreboard bench for cntr593_seq with a behavioural 74593 counter/register
// model hung off the strobes and a G-controlled Q bus.
module tb_cntr593_seq;

  logic       clk = 1'b0;
  logic       reset_bar = 1'b0;
  logic       clr_req = 1'b0, load_req = 1'b0, inc_req = 1'b0, oe_req = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       busy, done, shadow_valid, shadow_rco_bar;
  logic [1:0] done_op;
  logic [7:0] inQ, shadow;
  logic       RCK, RCKEN_bar, CLOAD_bar, CCK, CCKEN, CCKEN_bar, CCLR_bar, G, G_bar;

  cntr593_seq #(.WIDTH(8), .SETTLE(2)) dut (
    .clk(clk), .reset_bar(reset_bar), .clr_req(clr_req), .load_req(load_req),
    .inc_req(inc_req), .load_data(load_data), .oe_req(oe_req), .busy(busy),
    .done(done), .done_op(done_op), .inQ(inQ), .RCK(RCK), .RCKEN_bar(RCKEN_bar),
    .CLOAD_bar(CLOAD_bar), .CCK(CCK), .CCKEN(CCKEN), .CCKEN_bar(CCKEN_bar),
    .CCLR_bar(CCLR_bar), .G(G), .G_bar(G_bar), .shadow(shadow),
    .shadow_valid(shadow_valid), .shadow_rco_bar(shadow_rco_bar)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 74593: R loads on RCK rise, counter clears/increments on CCK
  // rise, counter loads from R on CLOAD_bar rise.
  logic [7:0] chip_r = 8'h00, chip_c = 8'h00;
  logic       rck_q = 1'b0, cck_q = 1'b1, cload_q = 1'b1;
  always @(RCK, CCK, CLOAD_bar) begin
    if (RCK === 1'b1 && rck_q !== 1'b1 && RCKEN_bar === 1'b0) chip_r = inQ;
    if (CCK === 1'b1 && cck_q !== 1'b1) begin
      if (CCLR_bar === 1'b0) chip_c = 8'h00;
      else if (CCKEN === 1'b1 && CCKEN_bar === 1'b0) chip_c = chip_c + 8'h01;
    end
    if (CLOAD_bar === 1'b1 && cload_q === 1'b0) chip_c = chip_r;
    rck_q = RCK; cck_q = CCK; cload_q = CLOAD_bar;
  end
  wire [7:0] q_bus = (G === 1'b1 && G_bar === 1'b0) ? chip_c : 8'hzz;

  // Pin activity totals; stimulus diffs snapshots of these
  int cclr_low_total = 0, cck_rise_total = 0, overlap_total = 0;
  int rck_rise_cyc = 0, cload_rise_cyc = 0;
  logic cck_s = 1'b1, rck_s = 1'b0, cload_s = 1'b1;
  always @(negedge clk) begin
    if (!CCLR_bar) cclr_low_total <= cclr_low_total + 1;
    if (CCK && !cck_s) cck_rise_total <= cck_rise_total + 1;
    if (RCK && !rck_s) rck_rise_cyc <= cyc;
    if (CLOAD_bar && !cload_s) cload_rise_cyc <= cyc;
    if ((!CLOAD_bar && (!CCLR_bar || CCKEN || !CCK)) ||
        (!CCLR_bar && (CCKEN || !RCKEN_bar)) || (CCKEN && !RCKEN_bar))
      overlap_total <= overlap_total + 1;
    cck_s <= CCK; rck_s <= RCK; cload_s <= CLOAD_bar;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] sh;
    logic       v;
    int         at;
    logic [7:0] q;
    bit         chkq;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] sh, input logic v,
                      input int at, input logic [7:0] q, input bit chkq);
    exp_t e;
    e.op = op; e.sh = sh; e.v = v; e.at = at; e.q = q; e.chkq = chkq;
    sb.push_back(e);
  endtask

  // One request held from IDLE until its done cycle
  task automatic single(input logic [1:0] op, input logic [7:0] d,
                        input logic [7:0] sh, input logic v, input bit chkq);
    int s, lat;
    @(negedge clk);
    s = cyc;
    load_data = d;
    case (op)
      2'b01:   begin clr_req = 1'b1;  lat = 7; end
      2'b10:   begin load_req = 1'b1; lat = 9; end
      default: begin inc_req = 1'b1;  lat = 5; end
    endcase
    push(op, sh, v, s + lat, sh, chkq);
    repeat (lat) @(negedge clk);
    clr_req = 1'b0; load_req = 1'b0; inc_req = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done_op), 32'h0);
        end else begin
          e = sb.pop_front();
          $display("done op=%0d shadow=%02h valid=%0d cycle=%0d q=%02h",
                   done_op, shadow, shadow_valid, cyc, q_bus);
          chk("done_op", 32'(done_op), 32'(e.op));
          chk("done_cycle", 32'(cyc), 32'(e.at));
          chk("shadow", 32'(shadow), 32'(e.sh));
          chk("shadow_valid", 32'(shadow_valid), 32'(e.v));
          chk("shadow_rco_bar", 32'(shadow_rco_bar), 32'(e.sh != 8'hFF));
          chk("busy_at_done", 32'(busy), 32'h0);
          if (e.chkq) chk("chip_q", 32'(q_bus), 32'(e.q));
        end
      end
    end
  endtask

  int s0, a0, a1;

  initial begin
    fork
      monitor();
      begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_pins", 32'({RCK, RCKEN_bar, CLOAD_bar, CCK, CCKEN, CCKEN_bar,
                               CCLR_bar, G, G_bar}), 32'h0ED);
        chk("reset_flags", 32'({busy, done, done_op, shadow_valid, shadow_rco_bar}), 32'h1);
        chk("reset_shadow_inq", 32'({shadow, inQ}), 32'h0);
        reset_bar = 1'b1;
        @(negedge clk);
        oe_req = 1'b1;
        @(negedge clk);
        chk("oe_G", 32'({G, G_bar}), 32'h2);

        // Clear
        a0 = cclr_low_total; a1 = cck_rise_total;
        single(2'b01, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("clr_cclr_low_cycles", 32'(cclr_low_total - a0), 32'd4);
        chk("clr_cck_rises", 32'(cck_rise_total - a1), 32'd1);

        // Load 0xA5
        single(2'b10, 8'hA5, 8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        chk("load_rck_to_cload", 32'(cload_rise_cyc - rck_rise_cyc), 32'd4);

        // Load 0xFE then two back-to-back increments with wrap
        single(2'b10, 8'hFE, 8'hFE, 1'b1, 1'b1);
        @(negedge clk);
        s0 = cyc;
        inc_req = 1'b1;
        push(2'b11, 8'hFF, 1'b1, s0 + 5, 8'hFF, 1'b1);
        push(2'b11, 8'h00, 1'b1, s0 + 11, 8'h00, 1'b1);
        repeat (11) @(negedge clk);
        inc_req = 1'b0;

        // All three requests at once: clr, then load, then inc
        @(negedge clk);
        s0 = cyc;
        load_data = 8'h3C;
        clr_req = 1'b1; load_req = 1'b1; inc_req = 1'b1;
        push(2'b01, 8'h00, 1'b1, s0 + 7, 8'h00, 1'b1);
        push(2'b10, 8'h3C, 1'b1, s0 + 17, 8'h3C, 1'b1);
        push(2'b11, 8'h3D, 1'b1, s0 + 23, 8'h3D, 1'b1);
        repeat (7) @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        load_req = 1'b0;
        repeat (6) @(negedge clk);
        inc_req = 1'b0;

        // Reset in the middle of a load's PH3
        @(negedge clk);
        load_data = 8'h55;
        load_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("load_ph3_cload_low", 32'(CLOAD_bar), 32'h0);
        reset_bar = 1'b0;
        load_req = 1'b0;
        #1;
        chk("abort_pins", 32'({RCK, RCKEN_bar, CLOAD_bar, CCK, CCKEN, CCKEN_bar,
                               CCLR_bar, G, G_bar}), 32'h0ED);
        chk("abort_busy_valid", 32'({busy, shadow_valid}), 32'h0);
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        @(negedge clk);
        oe_req = 1'b1;
        // Shadow counts from its reset value but stays unknown
        single(2'b11, 8'h00, 8'h01, 1'b0, 1'b0);

        // Reload, then toggle OE during an increment
        single(2'b10, 8'h10, 8'h10, 1'b1, 1'b1);
        @(negedge clk);
        s0 = cyc;
        inc_req = 1'b1;
        push(2'b11, 8'h11, 1'b1, s0 + 5, 8'h11, 1'b1);
        @(negedge clk);
        oe_req = 1'b0;
        chk("oe_lag_G_still_on", 32'({G, G_bar}), 32'h2);
        @(negedge clk);
        chk("oe_off_G", 32'({G, G_bar}), 32'h1);
        chk("oe_off_bus_z", 32'(q_bus), 32'hzz);
        oe_req = 1'b1;
        @(negedge clk);
        chk("oe_on_G", 32'({G, G_bar}), 32'h2);
        repeat (2) @(negedge clk);
        inc_req = 1'b0;

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        chk("strobe_overlap_cycles", 32'(overlap_total), 32'h0);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
